rs_pool: RTL
============

Name: rs_pool

Overview:
- Multi-entry, parametrised reservation station for the Tomasulo add/sub path. It succeeds the single-entry station.
- Holds up to ENTRIES issued instructions and snoops the CDB for pending operands.
- Dispatches ready instructions to the functional unit over a valid/ready handshake.
- Keeps each entry's tag reserved until the result for that tag is broadcast on the CDB.

Parameters:
- DATA_W, 16: operand and CDB data width.
- TAG_W, 3: producer tag width. Tag 0 means "no dependency".
- OP_W, 3: opcode width.
- ENTRIES, 4: number of station entries. Range 1..(2^TAG_W - BASE_TAG).
- BASE_TAG, 1: tag of entry 0. Entry i owns tag BASE_TAG+i.

Ports:
- CLK  in  1  clock, rising edge.
- CLR  in  1  synchronous active-high reset.
- issue_valid  in  1  issue request.
- issue_op  in  OP_W  opcode.
- issue_vj, issue_vk  in  DATA_W  register-file operand values.
- issue_qj, issue_qk  in  TAG_W  operand producer tags. 0 means the value is valid.
- issue_ready  out  1  at least one FREE entry.
- issue_tag  out  TAG_W  tag the next issue will receive.
- cdb_valid  in  1  CDB broadcast valid.
- cdb_tag  in  TAG_W  broadcast tag.
- cdb_data  in  DATA_W  broadcast value.
- ex_valid  out  1  dispatch valid.
- ex_ready  in  1  functional unit accepts.
- ex_op  out  OP_W  dispatched opcode.
- ex_a, ex_b  out  DATA_W  dispatched operands.
- ex_tag  out  TAG_W  dispatched entry tag.
- busy_count  out  clog2(ENTRIES+1)  number of non-FREE entries.

Behaviour:
- Interface: one clock CLK; reset CLR is synchronous and active-high. All state updates on the rising edge of CLK.
- Reset, on any edge with CLR=1, including mid-operation:
  - all entries go to FREE; Vj, Vk, Qj, Qk, op cleared to 0.
  - ex_valid=0, ex_op/ex_a/ex_b/ex_tag=0, busy_count=0.
  - issue_ready=1, issue_tag=BASE_TAG.
  - CLR overrides issue, CDB and dispatch in the same cycle.
- Entry states:
  - FREE -> WAIT on issue.
  - WAIT -> READY when Qj=0 and Qk=0.
  - READY -> EXEC on dispatch load.
  - EXEC -> FREE when cdb_valid and cdb_tag = own tag.
- Issue:
  - Occurs when issue_valid && issue_ready. Writes the lowest-index FREE entry.
  - issue_ready and issue_tag depend only on registered state. An entry freed by the CDB this cycle is not reusable until the next cycle.
  - issue_valid while issue_ready=0 is ignored with no state change.
- Issue-cycle CDB bypass: if cdb_valid and issue_qj = cdb_tag (nonzero), the entry stores Vj=cdb_data, Qj=0. The same rule applies independently to qk.
- An entry issued with both Q fields 0 after bypass enters READY directly.
- CDB snoop:
  - Every WAIT entry with Qj = cdb_tag (nonzero) captures Vj=cdb_data and Qj=0. Qk is handled the same way.
  - Multiple entries may capture the same broadcast.
  - cdb_tag=0 or cdb_valid=0 has no effect.
- Dispatch:
  - Output register is loaded when (!ex_valid || ex_ready) and some READY entry exists.
  - The selected entry is the lowest-index READY entry; it goes to EXEC.
  - If no READY entry exists and ex_ready is high, ex_valid drops to 0.
  - While ex_valid && !ex_ready, all ex_* outputs hold stable.
  - An entry becoming READY at edge N is dispatchable at edge N+1. Minimum issue-to-ex_valid latency is 2 edges.
- A CDB broadcast of an EXEC entry's tag and a snoop match on other entries in the same cycle are both applied.
- busy_count is the registered count of non-FREE entries, updated the same edge as the state changes.

Test Plan:
- CLR mid-operation with 3 entries busy and ex_valid=1 -> next cycle busy_count=0, ex_valid=0, issue_tag=1, issue_ready=1.
- Issue op=1, vj=5, vk=7, qj=qk=0; hold ex_ready=1 -> ex_valid=1 two edges later with ex_a=5, ex_b=7, ex_tag=1. Then CDB tag 1 -> busy_count returns to 0.
- Issue qj=3 into entry tag 1, then CDB tag 3 data 0x00AA -> entry goes READY and dispatches with ex_a=0x00AA. A CDB with tag 0 and data 0x00AA beforehand has no effect.
- Issue with qk=2 in the same cycle as CDB tag 2 data 0x1234 -> bypass captured; ex_b=0x1234 with no further broadcast.
- Fill all 4 entries -> issue_ready=0; a fifth issue is ignored. CDB frees tag 2 -> issue_ready=1 the next cycle and issue_tag=2.
- Two READY entries with ex_ready=0 for 3 cycles -> ex_* stable on tag 1. When ex_ready rises, the next load is tag 2.

Source files
------------

// File: rtl/rs_pool.sv
// rs_pool: multi-entry Tomasulo add/sub reservation station with CDB snoop and valid/ready dispatch
module rs_pool #(
    parameter int DATA_W   = 16,
    parameter int TAG_W    = 3,
    parameter int OP_W     = 3,
    parameter int ENTRIES  = 4,
    parameter int BASE_TAG = 1
) (
    input  logic                         CLK,
    input  logic                         CLR,
    input  logic                         issue_valid,
    input  logic [OP_W-1:0]              issue_op,
    input  logic [DATA_W-1:0]            issue_vj,
    input  logic [DATA_W-1:0]            issue_vk,
    input  logic [TAG_W-1:0]             issue_qj,
    input  logic [TAG_W-1:0]             issue_qk,
    output logic                         issue_ready,
    output logic [TAG_W-1:0]             issue_tag,
    input  logic                         cdb_valid,
    input  logic [TAG_W-1:0]             cdb_tag,
    input  logic [DATA_W-1:0]            cdb_data,
    output logic                         ex_valid,
    input  logic                         ex_ready,
    output logic [OP_W-1:0]              ex_op,
    output logic [DATA_W-1:0]            ex_a,
    output logic [DATA_W-1:0]            ex_b,
    output logic [TAG_W-1:0]             ex_tag,
    output logic [$clog2(ENTRIES+1)-1:0] busy_count
);
    localparam int IW = ENTRIES > 1 ? $clog2(ENTRIES) : 1;
    localparam int CW = $clog2(ENTRIES + 1);
    typedef enum logic [1:0] {FREE, WAIT, READY, EXEC} st_t;
    st_t               st   [ENTRIES];
    st_t               st_n [ENTRIES];
    logic [OP_W-1:0]   op   [ENTRIES];
    logic [OP_W-1:0]   op_n [ENTRIES];
    logic [DATA_W-1:0] vj   [ENTRIES];
    logic [DATA_W-1:0] vj_n [ENTRIES];
    logic [DATA_W-1:0] vk   [ENTRIES];
    logic [DATA_W-1:0] vk_n [ENTRIES];
    logic [TAG_W-1:0]  qj   [ENTRIES];
    logic [TAG_W-1:0]  qj_n [ENTRIES];
    logic [TAG_W-1:0]  qk   [ENTRIES];
    logic [TAG_W-1:0]  qk_n [ENTRIES];
    logic              free_hit, rdy_hit, cdb_hit, do_issue, load, bj, bk;
    logic [IW-1:0]     free_idx, rdy_idx;
    logic [CW-1:0]     cnt_n;

    function automatic logic [TAG_W-1:0] tag_of(input int i);
        return TAG_W'(BASE_TAG + i);
    endfunction

    always_comb begin
        free_hit = 1'b0;
        free_idx = '0;
        rdy_hit  = 1'b0;
        rdy_idx  = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (st[i] == FREE) begin
                free_hit = 1'b1;
                free_idx = IW'(i);
            end
            if (st[i] == READY) begin
                rdy_hit = 1'b1;
                rdy_idx = IW'(i);
            end
        end
    end

    // issue_ready/issue_tag come from registered state only, so a same-cycle CDB free is not reused
    assign issue_ready = free_hit;
    assign issue_tag   = tag_of(int'(free_idx));
    assign cdb_hit     = cdb_valid && cdb_tag != '0;
    assign do_issue    = issue_valid && free_hit;
    assign load        = (!ex_valid || ex_ready) && rdy_hit;
    assign bj          = cdb_hit && issue_qj == cdb_tag;
    assign bk          = cdb_hit && issue_qk == cdb_tag;

    always_comb begin
        cnt_n = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            st_n[i] = st[i];
            op_n[i] = op[i];
            vj_n[i] = vj[i];
            vk_n[i] = vk[i];
            qj_n[i] = qj[i];
            qk_n[i] = qk[i];
            if (st[i] == WAIT) begin
                if (cdb_hit && qj[i] == cdb_tag) begin
                    vj_n[i] = cdb_data;
                    qj_n[i] = '0;
                end
                if (cdb_hit && qk[i] == cdb_tag) begin
                    vk_n[i] = cdb_data;
                    qk_n[i] = '0;
                end
                if (qj_n[i] == '0 && qk_n[i] == '0) st_n[i] = READY;
            end
            if (st[i] == EXEC && cdb_valid && cdb_tag == tag_of(i)) st_n[i] = FREE;
            if (load && rdy_idx == IW'(i)) st_n[i] = EXEC;
            if (do_issue && free_idx == IW'(i)) begin
                op_n[i] = issue_op;
                vj_n[i] = bj ? cdb_data : issue_vj;
                vk_n[i] = bk ? cdb_data : issue_vk;
                qj_n[i] = bj ? '0 : issue_qj;
                qk_n[i] = bk ? '0 : issue_qk;
                if (qj_n[i] == '0 && qk_n[i] == '0) st_n[i] = READY;
                else st_n[i] = WAIT;
            end
            cnt_n = cnt_n + CW'(st_n[i] != FREE);
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            for (int i = 0; i < ENTRIES; i++) begin
                st[i] <= FREE;
                op[i] <= '0;
                vj[i] <= '0;
                vk[i] <= '0;
                qj[i] <= '0;
                qk[i] <= '0;
            end
            ex_valid   <= 1'b0;
            ex_op      <= '0;
            ex_a       <= '0;
            ex_b       <= '0;
            ex_tag     <= '0;
            busy_count <= '0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                st[i] <= st_n[i];
                op[i] <= op_n[i];
                vj[i] <= vj_n[i];
                vk[i] <= vk_n[i];
                qj[i] <= qj_n[i];
                qk[i] <= qk_n[i];
            end
            busy_count <= cnt_n;
            if (load) begin
                ex_valid <= 1'b1;
                ex_op    <= op[rdy_idx];
                ex_a     <= vj[rdy_idx];
                ex_b     <= vk[rdy_idx];
                ex_tag   <= tag_of(int'(rdy_idx));
            end else if (ex_ready) begin
                ex_valid <= 1'b0;
            end
        end
    end
endmodule
